// File: rtl/inertial_integrator.sv
// inertial_integrator: gyro offset calibration, rate compensation and pitch integration.
// Latency 2 cycles in RUN. A sample is accepted every cycle; there is no backpressure.
// Optional accelerometer fusion is enabled by defining INERT_ACCEL_FUSION_EN.
module inertial_integrator #(
   parameter int                 CAL_LOG2    = 3,
   parameter logic signed [15:0] AZ_OFFSET   = 16'sh00A0,
   parameter logic signed [9:0]  FUDGE       = 10'sd327,
   parameter logic signed [26:0] FUSION_STEP = 27'sd1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               smpl_vld,
   input  logic signed [15:0] ptch_rt_raw,
   input  logic signed [15:0] AZ,
   input  logic               recal,
   output logic               vld,
   output logic signed [15:0] ptch,
   output logic signed [15:0] ptch_rt
);

   localparam logic [0:0] CAL = 1'b0;
   localparam logic [0:0] RUN = 1'b1;
   localparam int ACC_W = 16 + CAL_LOG2;
   localparam logic signed [28:0] INT_MAX = 29'sd67108863;
   localparam logic signed [28:0] INT_MIN = -29'sd67108864;

   logic [0:0]              state;
   logic signed [ACC_W-1:0] cal_acc;
   logic signed [ACC_W-1:0] cal_acc_nxt;
   logic [CAL_LOG2-1:0]     cal_cnt;
   logic signed [15:0]      gyro_off;
   logic                    s1_vld;
   logic signed [15:0]      s1_rate;
   logic signed [26:0]      integ;
   logic signed [16:0]      rate_diff;
   logic signed [15:0]      rate_sat;
   logic signed [26:0]      fusion;
   logic signed [28:0]      integ_sum;
   logic signed [26:0]      integ_nxt;
   logic                    run_take;

   assign ptch     = integ[26:11];
   assign run_take = smpl_vld && !recal && (state == RUN);

   always_comb begin
      cal_acc_nxt = cal_acc + ACC_W'(ptch_rt_raw);
      rate_diff   = 17'(ptch_rt_raw) - 17'(gyro_off);
      if (rate_diff[16] != rate_diff[15])
         rate_sat = rate_diff[16] ? 16'sh8000 : 16'sh7FFF;
      else
         rate_sat = rate_diff[15:0];
      // Two guard bits so a single step can never wrap before the clamp sees it
      integ_sum = 29'(integ) - 29'(s1_rate) + 29'(fusion);
      if (integ_sum > INT_MAX)
         integ_nxt = INT_MAX[26:0];
      else if (integ_sum < INT_MIN)
         integ_nxt = INT_MIN[26:0];
      else
         integ_nxt = integ_sum[26:0];
   end

`ifdef INERT_ACCEL_FUSION_EN
   logic signed [15:0] az_diff;
   logic signed [25:0] accel_prod;
   logic signed [15:0] accel_nxt;
   logic signed [15:0] s1_accel;

   always_comb begin
      az_diff    = AZ - AZ_OFFSET;
      accel_prod = 26'(az_diff) * 26'(FUDGE);
      accel_nxt  = 16'(accel_prod >>> 13);
      fusion     = (s1_accel > ptch) ? FUSION_STEP : -FUSION_STEP;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         s1_accel <= '0;
      else if (recal)
         s1_accel <= '0;
      else if (run_take)
         s1_accel <= accel_nxt;
   end
`else
   logic unused_accel;
   assign unused_accel = ^{AZ, AZ_OFFSET, FUDGE, FUSION_STEP};
   assign fusion       = '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= CAL;
         cal_acc  <= '0;
         cal_cnt  <= '0;
         gyro_off <= '0;
         s1_vld   <= 1'b0;
         s1_rate  <= '0;
         vld      <= 1'b0;
         integ    <= '0;
         ptch_rt  <= '0;
      end else if (recal) begin
         // Any sample presented alongside recal is discarded, in-flight work dropped
         state    <= CAL;
         cal_acc  <= '0;
         cal_cnt  <= '0;
         gyro_off <= '0;
         s1_vld   <= 1'b0;
         s1_rate  <= '0;
         vld      <= 1'b0;
         integ    <= '0;
         ptch_rt  <= '0;
      end else begin
         s1_vld <= 1'b0;
         vld    <= s1_vld;
         if (smpl_vld && state == CAL) begin
            cal_acc <= cal_acc_nxt;
            cal_cnt <= cal_cnt + 1'b1;
            if (cal_cnt == '1) begin
               gyro_off <= 16'(cal_acc_nxt >>> CAL_LOG2);
               state    <= RUN;
            end
         end
         if (run_take) begin
            s1_vld  <= 1'b1;
            s1_rate <= rate_sat;
         end
         if (s1_vld) begin
            integ   <= integ_nxt;
            ptch_rt <= s1_rate;
         end
      end
   end

endmodule
